// File: rtl/tron_pkg.sv
// ---------------------------------------------------------------------------
// tron_pkg
// Definitions shared by the PC/branch stage and any other condition consumer:
//   - br_type_e : instruction redirect class (SEQ, BCOND, JCOND, JAL)
//   - Cond*     : 4-bit condition-code constants
//   - FLAG_*    : bit positions inside the 5-bit ALU flag register
//   - state_e   : PC unit run/halt state
// ---------------------------------------------------------------------------
package tron_pkg;

    typedef enum logic [1:0] {
        BrSeq   = 2'b00,
        BrBcond = 2'b01,
        BrJcond = 2'b10,
        BrJal   = 2'b11
    } br_type_e;

    localparam logic [3:0] CondEq = 4'd0;
    localparam logic [3:0] CondNe = 4'd1;
    localparam logic [3:0] CondCs = 4'd2;
    localparam logic [3:0] CondCc = 4'd3;
    localparam logic [3:0] CondHi = 4'd4;
    localparam logic [3:0] CondLs = 4'd5;
    localparam logic [3:0] CondGt = 4'd6;
    localparam logic [3:0] CondLe = 4'd7;
    localparam logic [3:0] CondFs = 4'd8;
    localparam logic [3:0] CondFc = 4'd9;
    localparam logic [3:0] CondLo = 4'd10;
    localparam logic [3:0] CondHs = 4'd11;
    localparam logic [3:0] CondLt = 4'd12;
    localparam logic [3:0] CondGe = 4'd13;
    localparam logic [3:0] CondUc = 4'd14;
    localparam logic [3:0] CondNv = 4'd15;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_L = 1;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 4;

    typedef enum logic {
        StRun  = 1'b0,
        StHalt = 1'b1
    } state_e;

endpackage

// File: rtl/branch_pc_unit_if.sv
// ---------------------------------------------------------------------------
// branch_pc_unit_if
// Bundle between the controller/ALU side (master) and the PC unit (slave).
//   master drives : flagreg, pcWrite, brType, cond, disp, target
//   slave drives  : pc, link, taken, halted
// ---------------------------------------------------------------------------
interface branch_pc_unit_if #(
    parameter int unsigned WIDTH = 16
);
    logic [4:0]       flagreg;
    logic             pcWrite;
    logic [1:0]       brType;
    logic [3:0]       cond;
    logic [7:0]       disp;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] link;
    logic             taken;
    logic             halted;

    modport master (
        output flagreg, pcWrite, brType, cond, disp, target,
        input  pc, link, taken, halted
    );

    modport slave (
        input  flagreg, pcWrite, brType, cond, disp, target,
        output pc, link, taken, halted
    );
endinterface

// File: rtl/branch_pc_unit_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational condition-code decoder.
//   flagreg  in  5  ALU flags {N,Z,F,L,C}
//   cond     in  4  condition code
//   condTrue out 1  condition holds for the given flags
// ---------------------------------------------------------------------------
module cond_eval
    import tron_pkg::*;
(
    input  logic [4:0] flagreg,
    input  logic [3:0] cond,
    output logic       condTrue
);
    logic w_c, w_l, w_f, w_z, w_n;

    assign w_c = flagreg[FLAG_C];
    assign w_l = flagreg[FLAG_L];
    assign w_f = flagreg[FLAG_F];
    assign w_z = flagreg[FLAG_Z];
    assign w_n = flagreg[FLAG_N];

    always_comb begin
        condTrue = 1'b0;
        case (cond)
            CondEq:  condTrue = w_z;
            CondNe:  condTrue = ~w_z;
            CondCs:  condTrue = w_c;
            CondCc:  condTrue = ~w_c;
            CondHi:  condTrue = w_l;
            CondLs:  condTrue = ~w_l;
            CondGt:  condTrue = w_n;
            CondLe:  condTrue = ~w_n;
            CondFs:  condTrue = w_f;
            CondFc:  condTrue = ~w_f;
            CondLo:  condTrue = ~w_l & ~w_z;
            CondHs:  condTrue = w_l | w_z;
            CondLt:  condTrue = ~w_n & ~w_z;
            CondGe:  condTrue = w_n | w_z;
            CondUc:  condTrue = 1'b1;
            CondNv:  condTrue = 1'b0;
            default: condTrue = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_pc_unit.sv
// ---------------------------------------------------------------------------
// branch_pc_unit
// Architectural PC register, JAL link register and run/halt FSM.
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of branch_pc_unit_if:
//            flagreg/pcWrite/brType/cond/disp/target in,
//            pc/link/taken/halted out
// A retiring BCOND to itself with condition UC parks the unit in HALT until
// reset.
// ---------------------------------------------------------------------------
module branch_pc_unit
    import tron_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    branch_pc_unit_if.slave    bus
);
    logic [WIDTH-1:0] r_pc, w_pc_d;
    logic [WIDTH-1:0] r_link, w_link_d;
    logic             r_taken, w_taken_d;
    state_e           r_state, w_state_d;

    logic             w_cond_true;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_pc_disp;
    br_type_e         w_br_type;
    logic             w_self_loop;

    cond_eval u_cond_eval (
        .flagreg  (bus.flagreg),
        .cond     (bus.cond),
        .condTrue (w_cond_true)
    );

    assign w_br_type   = br_type_e'(bus.brType);
    assign w_pc_inc    = r_pc + WIDTH'(1);
    assign w_pc_disp   = r_pc + {{(WIDTH-8){bus.disp[7]}}, bus.disp};
    assign w_self_loop = (bus.cond == CondUc) && (bus.disp == 8'h00);

    always_comb begin
        w_pc_d    = r_pc;
        w_link_d  = r_link;
        w_taken_d = 1'b0;
        w_state_d = r_state;
        if (r_state == StRun && bus.pcWrite) begin
            unique case (w_br_type)
                BrSeq: begin
                    w_pc_d = w_pc_inc;
                end
                BrBcond: begin
                    if (w_cond_true) begin
                        w_pc_d    = w_pc_disp;
                        w_taken_d = 1'b1;
                    end else begin
                        w_pc_d = w_pc_inc;
                    end
                    // UC with zero displacement is the program-end idiom.
                    if (w_self_loop) begin
                        w_state_d = StHalt;
                    end
                end
                BrJcond: begin
                    if (w_cond_true) begin
                        w_pc_d    = bus.target;
                        w_taken_d = 1'b1;
                    end else begin
                        w_pc_d = w_pc_inc;
                    end
                end
                BrJal: begin
                    w_link_d  = w_pc_inc;
                    w_pc_d    = bus.target;
                    w_taken_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc    <= RESET_PC;
            r_link  <= '0;
            r_taken <= 1'b0;
            r_state <= StRun;
        end else begin
            r_pc    <= w_pc_d;
            r_link  <= w_link_d;
            r_taken <= w_taken_d;
            r_state <= w_state_d;
        end
    end

    assign bus.pc     = r_pc;
    assign bus.link   = r_link;
    assign bus.taken  = r_taken;
    assign bus.halted = (r_state == StHalt);
endmodule

// File: tb/tb_branch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_pc_unit
// Directed and random stimulus against a spec-level reference model of the
// PC unit (integer PC arithmetic modulo 2^16, table-driven condition decode).
// ---------------------------------------------------------------------------
module tb_branch_pc_unit;
    localparam int unsigned      WIDTH    = 16;
    localparam logic [WIDTH-1:0] RESET_PC = 16'h0000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    branch_pc_unit_if #(.WIDTH(WIDTH)) bus ();

    branch_pc_unit #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pc;
    int m_link;
    int m_taken;
    int m_halted;

    function automatic int ref_cond(input logic [4:0] f, input int c);
        bit cf, lf, ff, zf, nf;
        cf = f[0]; lf = f[1]; ff = f[2]; zf = f[3]; nf = f[4];
        case (c)
            0:  return int'(zf);
            1:  return int'(!zf);
            2:  return int'(cf);
            3:  return int'(!cf);
            4:  return int'(lf);
            5:  return int'(!lf);
            6:  return int'(nf);
            7:  return int'(!nf);
            8:  return int'(ff);
            9:  return int'(!ff);
            10: return int'(!lf && !zf);
            11: return int'(lf || zf);
            12: return int'(!nf && !zf);
            13: return int'(nf || zf);
            14: return 1;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},     32'(bus.pc),     32'(m_pc));
        chk({tag, ".link"},   32'(bus.link),   32'(m_link));
        chk({tag, ".taken"},  32'(bus.taken),  32'(m_taken));
        chk({tag, ".halted"}, 32'(bus.halted), 32'(m_halted));
    endtask

    // One clock: drive inputs, advance the model by the spec rules, compare.
    task automatic step(input string tag, input bit w, input int bt, input int c,
                        input logic [7:0] d, input int t, input logic [4:0] f);
        int nt;
        bus.pcWrite = w;
        bus.brType  = 2'(bt);
        bus.cond    = 4'(c);
        bus.disp    = d;
        bus.target  = 16'(t);
        bus.flagreg = f;
        @(posedge clk);
        #1;
        nt = 0;
        if (m_halted == 0 && w) begin
            if (bt == 0) begin
                m_pc = (m_pc + 1) % 65536;
            end else if (bt == 1) begin
                if (ref_cond(f, c) != 0) begin
                    m_pc = (m_pc + int'($signed(d)) + 65536) % 65536;
                    nt   = 1;
                end else begin
                    m_pc = (m_pc + 1) % 65536;
                end
                if (c == 14 && d == 8'h00) m_halted = 1;
            end else if (bt == 2) begin
                if (ref_cond(f, c) != 0) begin
                    m_pc = t % 65536;
                    nt   = 1;
                end else begin
                    m_pc = (m_pc + 1) % 65536;
                end
            end else begin
                m_link = (m_pc + 1) % 65536;
                m_pc   = t % 65536;
                nt     = 1;
            end
        end
        m_taken = nt;
        chk_all(tag);
    endtask

    initial begin
        bus.pcWrite = 1'b0;
        bus.brType  = 2'd0;
        bus.cond    = 4'd0;
        bus.disp    = 8'd0;
        bus.target  = '0;
        bus.flagreg = 5'd0;
        m_pc = int'(RESET_PC); m_link = 0; m_taken = 0; m_halted = 0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Sequential fetch 1..4
        for (int i = 0; i < 4; i++) begin
            step("seq", 1'b1, 0, 0, 8'h00, 0, 5'd0);
            chk("seq.pc_abs", 32'(bus.pc), 32'(i + 1));
        end

        // BCOND EQ taken backwards from 0x0010
        step("set10", 1'b1, 2, 14, 8'h00, 16'h0010, 5'd0);
        step("beq_t", 1'b1, 1, 0, 8'hF8, 0, 5'b01000);
        chk("beq_t.pc_abs", 32'(bus.pc), 32'h0008);
        chk("beq_t.taken_abs", 32'(bus.taken), 32'd1);
        step("set10b", 1'b1, 2, 14, 8'h00, 16'h0010, 5'd0);
        step("beq_nt", 1'b1, 1, 0, 8'hF8, 0, 5'b00000);
        chk("beq_nt.pc_abs", 32'(bus.pc), 32'h0011);
        chk("beq_nt.taken_abs", 32'(bus.taken), 32'd0);

        // Negative displacement wrapping below zero
        step("set02", 1'b1, 2, 14, 8'h00, 16'h0002, 5'd0);
        step("bwrap", 1'b1, 1, 14, 8'hFC, 0, 5'd0);
        chk("bwrap.pc_abs", 32'(bus.pc), 32'hFFFE);

        // Full condition sweep on JCOND
        for (int f = 0; f < 32; f++) begin
            for (int c = 0; c < 16; c++) begin
                step("jsweep", 1'b1, 2, c, 8'h00, 16'h1234, 5'(f));
            end
        end

        // JAL to 0xFFFF then wrap on SEQ
        step("setA0", 1'b1, 2, 14, 8'h00, 16'h00A0, 5'd0);
        step("jal", 1'b1, 3, 0, 8'h00, 16'hFFFF, 5'd0);
        chk("jal.link_abs", 32'(bus.link), 32'h00A1);
        chk("jal.pc_abs", 32'(bus.pc), 32'hFFFF);
        step("wrap", 1'b1, 0, 0, 8'h00, 0, 5'd0);
        chk("wrap.pc_abs", 32'(bus.pc), 32'h0000);

        // pcWrite low with JAL presented: nothing moves
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b0, 3, 14, 8'h10, 16'h5555, 5'd0);
            chk("hold.pc_abs", 32'(bus.pc), 32'h0000);
            chk("hold.link_abs", 32'(bus.link), 32'h00A1);
        end

        // Random traffic; the self-loop halt pattern is steered away here
        for (int i = 0; i < 300; i++) begin
            int          bt, c, t;
            logic [7:0]  d;
            logic [4:0]  f;
            bit          w;
            bt = int'($urandom_range(0, 3));
            c  = int'($urandom_range(0, 15));
            d  = 8'($urandom);
            t  = int'($urandom_range(0, 65535));
            f  = 5'($urandom);
            w  = ($urandom_range(0, 3) != 0);
            if (bt == 1 && c == 14 && d == 8'h00) d = 8'h01;
            step("rand", w, bt, c, d, t, f);
        end

        // Halt on branch-to-self at 0x0040
        step("set40", 1'b1, 2, 14, 8'h00, 16'h0040, 5'd0);
        step("halt", 1'b1, 1, 14, 8'h00, 0, 5'd0);
        chk("halt.halted_abs", 32'(bus.halted), 32'd1);
        chk("halt.taken_abs", 32'(bus.taken), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step("halted", 1'b1, 0, 0, 8'h00, 0, 5'd0);
            chk("halted.pc_abs", 32'(bus.pc), 32'h0040);
        end

        // Asynchronous reset mid-cycle leaves HALT immediately
        #3;
        reset_n = 1'b0;
        #1;
        m_pc = int'(RESET_PC); m_link = 0; m_taken = 0; m_halted = 0;
        chk_all("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        step("post_rst", 1'b1, 0, 0, 8'h00, 0, 5'd0);
        chk("post_rst.pc_abs", 32'(bus.pc), 32'(RESET_PC) + 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and branch-resolution stage directly downstream of the ALU. Holds the architectural PC, consumes the 5-bit flag register the ALU updates on the falling clock edge, and resolves conditional branches, conditional jumps and jump-and-link. Supplies the fetch address, the link value for register writeback, a taken pulse for the controller's flush logic, and a halt indication for self-loop program termination.

## Interface
Parameters:
- WIDTH, 16, PC/address and data width
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flagreg  in  5  ALU flags: bit0 C carry, bit1 L low, bit2 F overflow, bit3 Z equal, bit4 N negative
- pcWrite  in  1  instruction retires this cycle; PC may update
- brType  in  2  00 SEQ, 01 BCOND, 10 JCOND, 11 JAL
- cond  in  4  condition code for BCOND/JCOND
- disp  in  8  signed branch displacement (BCOND)
- target  in  WIDTH  jump target register value (JCOND/JAL)
- pc  out  WIDTH  current fetch address
- link  out  WIDTH  return address captured by JAL
- taken  out  1  one-cycle pulse: previous retiring instruction redirected the PC
- halted  out  1  unit in HALT state

## Operation
- Condition decode: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N; 8 FS F; 9 FC !F; 10 LO !L&!Z; 11 HS L|Z; 12 LT !N&!Z; 13 GE N|Z; 14 UC 1; 15 never 0.
- SEQ: pc <= pc+1. BCOND: if cond true pc <= pc + sext(disp) else pc+1. JCOND: if cond true pc <= target else pc+1. JAL: unconditional; link <= pc+1, pc <= target.
- All address arithmetic modulo 2^WIDTH (wrap 0xFFFF+1 -> 0x0000; pc 0x0002 + disp 0xFC -> 0xFFFE).
- taken <= 1 when a retiring BCOND/JCOND evaluates true or JAL retires; else 0.
- FSM: RUN, HALT. RUN -> HALT when pcWrite & BCOND & cond=UC & disp=0 (branch-to-self). In HALT pc, link frozen, taken=0, halted=1; only reset exits.
- pcWrite=0: pc, link hold; taken <= 0.

## Timing
- Reset (async assert, sync-free deassert): pc=RESET_PC, link=0, taken=0, halted=0, state RUN.
- Flags written by ALU on falling edge are stable at next rising edge; a CMP retiring in cycle n is visible to a branch retiring in cycle n+1.
- pc, link, taken, halted update on the rising edge where pcWrite=1; latency 1 cycle, no bubbles inside the block.
- The halting branch itself sets taken=1 on the entry edge; taken drops to 0 the following cycle.
- Reset asserted mid-operation overrides everything immediately, including HALT.
- brType/cond/disp/target are don't-care when pcWrite=0.

## Structure
- Shared package tron_pkg: brType encodings, 4-bit condition-code constants, flag bit indices (FLAG_C..FLAG_N), FSM state encoding.
- One combinational sub-module cond_eval (flagreg, cond -> condTrue), reusable by other condition consumers; the PC register, link register and FSM stay in branch_pc_unit.

## Test plan
- Reset, then 4 cycles pcWrite=1 SEQ -> pc 0,1,2,3,4; taken 0; halted 0.
- pc=0x0010, flags Z=1, BCOND cond=EQ disp=0xF8 -> pc=0x0008, taken=1 next cycle; same with Z=0 -> pc=0x0011, taken=0.
- Full cond sweep: all 32 flag combinations x 16 codes on JCOND target=0x1234 -> pc=0x1234 exactly when the decode table is true, else pc+1.
- pc=0x00A0, JAL target=0xFFFF -> link=0x00A1, pc=0xFFFF; next SEQ -> pc=0x0000 (wrap).
- pc=0x0040, BCOND UC disp=0 -> halted=1, pc stays 0x0040 for 10 cycles despite pcWrite=1 SEQ; assert reset_n low mid-cycle -> pc=RESET_PC, halted=0 immediately.
- pcWrite=0 for 3 cycles with JAL on inputs -> pc, link unchanged, taken 0.
